// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_t    - fetch FSM state encoding
//   RST_VEC_HI_ADDR  - word address holding PC[31:16] of the start vector
//   RST_VEC_LO_ADDR  - word address holding PC[15:0] of the start vector
//   IMM_BIT_DEFAULT  - default position of the two-word (immediate) flag
package fetch_pkg;

    typedef enum logic [1:0] {
        RST_HI    = 2'd0,
        RST_LO    = 2'd1,
        FETCH     = 2'd2,
        FETCH_IMM = 2'd3
    } fetch_state_t;

    localparam int RST_VEC_HI_ADDR = 0;
    localparam int RST_VEC_LO_ADDR = 1;
    localparam int IMM_BIT_DEFAULT = 15;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: bundles the instruction-memory bus, the downstream control
// inputs (stall / redirect) and the IF/ID bundle outputs.
//   master - the fetch unit side
//   slave  - memory / decode / hazard-unit side
//
// Bundle semantics: if_valid=1 marks a real instruction on if_*; while
// stall=1 the bundle is held unchanged and decode must keep re-reading it;
// redirect=1 wins over stall and turns the next bundle into a bubble.
interface fetch_if #(
    parameter int ADDR_W = 20
);
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_data;
    logic              stall;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              if_valid;
    logic [15:0]       if_instr;
    logic [15:0]       if_imm;
    logic [31:0]       if_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        input  stall,
        input  redirect,
        input  redirect_pc,
        output if_valid,
        output if_instr,
        output if_imm,
        output if_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output stall,
        output redirect,
        output redirect_pc,
        input  if_valid,
        input  if_instr,
        input  if_imm,
        input  if_pc
    );
endinterface

// File: rtl/pc_register.sv
// pc_register: 32-bit program counter.
//   clk, rst  - clock, asynchronous active-high reset (pc -> 0)
//   load      - take load_val (redirect target or reset-vector halves)
//   load_val  - value loaded when load=1
//   inc       - advance by one word (wraps at 2^32); load has priority
//   pc        - current program counter
// With neither load nor inc the PC holds.
module pc_register (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        inc,
    output logic [31:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning the IF/ID register.
//   clk, rst - pipeline clock, asynchronous active-high reset
//   bus      - fetch_if master: imem_addr/imem_data, stall, redirect,
//              redirect_pc, if_valid/if_instr/if_imm/if_pc
//   state    - current FSM state (debug observation)
// After reset the start PC is read from words 0 (high half) and 1 (low
// half); then 16-bit words stream out, and a word with IMM_BIT set is
// merged with the following word into a single bundle.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int IMM_BIT = IMM_BIT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    fetch_if.master       bus,
    output fetch_state_t  state
);

    fetch_state_t      state_next;
    logic [31:0]       pc;
    logic              pc_load;
    logic [31:0]       pc_load_val;
    logic              pc_inc;
    logic [ADDR_W-1:0] imem_addr_c;

    // IF/ID update controls decoded by the FSM
    logic              id_bubble;
    logic              id_single;
    logic              id_pair;
    logic              pend_load;

    logic [15:0]       pending_instr;
    logic [31:0]       pending_pc;

    pc_register u_pc (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc)
    );

    assign bus.imem_addr = imem_addr_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_HI;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_load     = 1'b0;
        pc_load_val = pc;
        pc_inc      = 1'b0;
        imem_addr_c = pc[ADDR_W-1:0];
        id_bubble   = 1'b0;
        id_single   = 1'b0;
        id_pair     = 1'b0;
        pend_load   = 1'b0;
        case (state)
            RST_HI: begin
                // Start-vector halves are merged into the PC one at a time.
                imem_addr_c = ADDR_W'(RST_VEC_HI_ADDR);
                pc_load     = 1'b1;
                pc_load_val = {bus.imem_data, pc[15:0]};
                id_bubble   = 1'b1;
                state_next  = RST_LO;
            end
            RST_LO: begin
                imem_addr_c = ADDR_W'(RST_VEC_LO_ADDR);
                pc_load     = 1'b1;
                pc_load_val = {pc[31:16], bus.imem_data};
                id_bubble   = 1'b1;
                state_next  = FETCH;
            end
            FETCH, FETCH_IMM: begin
                if (bus.redirect) begin
                    // A half-assembled two-word bundle is dropped by
                    // returning to FETCH; pending is simply never used.
                    pc_load     = 1'b1;
                    pc_load_val = bus.redirect_pc;
                    id_bubble   = 1'b1;
                    state_next  = FETCH;
                end else if (!bus.stall) begin
                    pc_inc = 1'b1;
                    if (state == FETCH_IMM) begin
                        id_pair    = 1'b1;
                        state_next = FETCH;
                    end else if (bus.imem_data[IMM_BIT]) begin
                        pend_load  = 1'b1;
                        id_bubble  = 1'b1;
                        state_next = FETCH_IMM;
                    end else begin
                        id_single  = 1'b1;
                    end
                end
            end
            default: state_next = RST_HI;
        endcase
    end

    // Pending first word of a two-word instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_instr <= '0;
            pending_pc    <= '0;
        end else if (pend_load) begin
            pending_instr <= bus.imem_data;
            pending_pc    <= pc;
        end
    end

    // IF/ID pipeline register; a bubble only clears valid, data fields hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.if_valid <= 1'b0;
            bus.if_instr <= '0;
            bus.if_imm   <= '0;
            bus.if_pc    <= '0;
        end else if (id_bubble) begin
            bus.if_valid <= 1'b0;
        end else if (id_single) begin
            bus.if_valid <= 1'b1;
            bus.if_instr <= bus.imem_data;
            bus.if_imm   <= '0;
            bus.if_pc    <= pc;
        end else if (id_pair) begin
            bus.if_valid <= 1'b1;
            bus.if_instr <= pending_instr;
            bus.if_imm   <= bus.imem_data;
            bus.if_pc    <= pending_pc;
        end
    end

endmodule
